// File: rtl/alu_mc.sv
// alu_mc: registered N-bit signed ALU. add/sub/logic/shift finish in one cycle; div/rem
// (and mul when the ALU_MC_MUL_EN macro is defined) iterate N cycles on operand magnitudes.
module alu_mc #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ctrl,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         busy,
    output logic         done
);

    localparam int            CW     = $clog2(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [N-1:0]  C_N    = N'(N);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0111;
`endif
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_REM = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIV, K_REM}    kind_t;

    state_t        r_state;
    kind_t         r_kind;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_dvd;
    logic [N-1:0]  r_dvs;
    logic [N-1:0]  r_rem;
    logic          r_neg_a;
    logic          r_neg_q;
    logic          r_div0;

    logic          w_accept;
    logic          w_is_iter;
    kind_t         w_kind;
    logic [N:0]    w_add;
    logic [N-1:0]  w_sub;
    logic [N-1:0]  w_sra;
    logic [N-1:0]  w_mag_a;
    logic [N-1:0]  w_mag_b;
    logic [N-1:0]  w_sc_res;
    logic          w_sc_c;
    logic          w_sc_v;
    logic [N:0]    w_div_shift;
    logic [N:0]    w_div_diff;
    logic          w_div_ge;
    logic [N-1:0]  w_rem_nxt;
    logic [N-1:0]  w_dvd_nxt;
    logic [N-1:0]  w_fin_res;
    logic          w_fin_v;
`ifdef ALU_MC_MUL_EN
    logic [N:0]    w_mul_sum;
    logic [2*N-1:0] w_sprod;
`endif

    function automatic logic [3:0] mk_flags(input logic [N-1:0] res, input logic c, input logic v);
        return {res[N-1], (res == '0), c, v};
    endfunction

    assign w_accept = start && !busy;
    assign w_add    = {1'b0, a} + {1'b0, b};
    assign w_sub    = a - b;
    assign w_sra    = $signed(a) >>> b;
    assign w_mag_a  = a[N-1] ? -a : a;
    assign w_mag_b  = b[N-1] ? -b : b;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                w_sc_res = w_add[N-1:0];
                w_sc_c   = w_add[N];
                w_sc_v   = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_sc_res = w_sub;
                w_sc_v   = (a[N-1] != b[N-1]) && (w_sub[N-1] != a[N-1]);
            end
            OP_AND:  w_sc_res = a & b;
            OP_OR:   w_sc_res = a | b;
            OP_XOR:  w_sc_res = a ^ b;
            OP_SHL:  w_sc_res = (b >= C_N) ? '0 : (a << b);
            OP_SHR:  w_sc_res = (b >= C_N) ? {N{a[N-1]}} : w_sra;
            default: w_sc_res = '0;
        endcase
    end

    always_comb begin
        w_is_iter = 1'b0;
        w_kind    = K_DIV;
        case (ctrl)
            OP_DIV: w_is_iter = 1'b1;
            OP_REM: begin
                w_is_iter = 1'b1;
                w_kind    = K_REM;
            end
`ifdef ALU_MC_MUL_EN
            OP_MUL: begin
                w_is_iter = 1'b1;
                w_kind    = K_MUL;
            end
`endif
            default: w_is_iter = 1'b0;
        endcase
    end

    // Restoring divide step: r_dvd shifts the dividend out and the quotient in.
    assign w_div_shift = {r_rem, r_dvd[N-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_dvs};
    assign w_div_ge    = !w_div_diff[N];
`ifdef ALU_MC_MUL_EN
    assign w_mul_sum   = {1'b0, r_rem} + (r_dvd[0] ? {1'b0, r_dvs} : '0);
`endif

    always_comb begin
        w_rem_nxt = w_div_ge ? w_div_diff[N-1:0] : w_div_shift[N-1:0];
        w_dvd_nxt = {r_dvd[N-2:0], w_div_ge};
`ifdef ALU_MC_MUL_EN
        // Shift-add multiply: {r_rem, r_dvd} is the product register, multiplier in the low half.
        if (r_kind == K_MUL) begin
            w_rem_nxt = w_mul_sum[N:1];
            w_dvd_nxt = {w_mul_sum[0], r_dvd[N-1:1]};
        end
`endif
    end

    always_comb begin
        w_fin_res = '0;
        w_fin_v   = 1'b0;
`ifdef ALU_MC_MUL_EN
        w_sprod   = r_neg_q ? -{w_rem_nxt, w_dvd_nxt} : {w_rem_nxt, w_dvd_nxt};
`endif
        case (r_kind)
            K_DIV: begin
                if (r_div0) begin
                    w_fin_v = 1'b1;
                end else begin
                    w_fin_res = r_neg_q ? -w_dvd_nxt : w_dvd_nxt;
                    w_fin_v   = !r_neg_q && w_dvd_nxt[N-1];
                end
            end
            K_REM: begin
                if (r_div0) begin
                    w_fin_v = 1'b1;
                end else begin
                    w_fin_res = r_neg_a ? -w_rem_nxt : w_rem_nxt;
                end
            end
`ifdef ALU_MC_MUL_EN
            K_MUL: begin
                w_fin_res = w_sprod[N-1:0];
                w_fin_v   = (w_sprod[2*N-1:N-1] != '0) && (w_sprod[2*N-1:N-1] != '1);
            end
`endif
            default: w_fin_res = '0;
        endcase
    end

    // NOTE: working registers carry no reset; acceptance always loads them before they are read.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_iter) begin
            r_kind  <= w_kind;
            r_dvd   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_rem   <= '0;
            r_neg_a <= a[N-1];
            r_neg_q <= a[N-1] ^ b[N-1];
            r_div0  <= (b == '0);
        end else if (busy) begin
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem_nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            result  <= '0;
            flags   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= w_fin_res;
                        flags   <= mk_flags(w_fin_res, 1'b0, w_fin_v);
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_is_iter) begin
                            r_state <= S_ITER;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            result  <= w_sc_res;
                            flags   <= mk_flags(w_sc_res, w_sc_c, w_sc_v);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
